// File: rtl/nn_drv_pkg.sv
// Shared types and constants for the dense-layer core sequencing front end.
package nn_drv_pkg;

    typedef enum logic [2:0] {
        S_LO,
        S_HI,
        S_RUN,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [15:0] TIMEOUT_CODE = 16'h8000;
    localparam int          DEF_DW       = 16;
    localparam int          DEF_TIMEOUT  = 64;
    localparam int          DEF_ERRW     = 8;

endpackage

// File: rtl/nn_watchdog.sv
// Inference watchdog: counts cycles while enabled and flags the last permitted cycle.
module nn_watchdog
    import nn_drv_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = en && (count_q == LAST);

endmodule

// File: rtl/nn_infer_driver.sv
// Packs feature pairs for the HLS dense-layer core, runs its start/done handshake,
// and re-presents the result (or a timeout/missing-result code) on a valid/ready stream.
module nn_infer_driver
    import nn_drv_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ERRW    = DEF_ERRW
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DW-1:0]     s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic              core_start,
    input  logic              core_idle,
    input  logic              core_done,
    output logic [2*DW-1:0]   core_in,
    output logic              core_in_vld,
    input  logic [DW-1:0]     core_out,
    input  logic              core_out_vld,
    output logic [DW-1:0]     m_tdata,
    output logic              m_tuser,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              busy,
    output logic [ERRW-1:0]   err_count
);
    state_t            state_q, state_d;
    logic              s_tready_q, s_tready_d;
    logic              core_start_q, core_start_d;
    logic [2*DW-1:0]   core_in_q, core_in_d;
    logic [DW-1:0]     result_q, result_d;
    logic              seen_q, seen_d;
    logic [DW-1:0]     m_tdata_q, m_tdata_d;
    logic              m_tuser_q, m_tuser_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              busy_q, busy_d;
    logic [ERRW-1:0]   err_q, err_d;

    logic s_hs, m_hs, wd_expire, seen_now, wait_exit, err_now;

    assign s_hs      = s_tvalid && s_tready_q;
    assign m_hs      = m_tvalid_q && m_tready;
    assign seen_now  = seen_q || core_out_vld;
    assign wait_exit = (state_q == S_WAIT) && (core_done || wd_expire);
    // core_done wins over a same-cycle expiry, so only a missing result makes it an error
    assign err_now   = wait_exit && (core_done ? !seen_now : 1'b1);

    nn_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (ap_clk),
        .rst    (ap_rst),
        .clr    (core_start_q),
        .en     (state_q == S_WAIT),
        .expire (wd_expire)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LO:    if (s_hs) state_d = S_HI;
            S_HI:    if (s_hs) state_d = S_RUN;
            S_RUN:   if (core_start_q) state_d = S_WAIT;
            S_WAIT:  if (core_done || wd_expire) state_d = S_OUT;
            S_OUT:   if (m_hs) state_d = S_LO;
            default: state_d = S_LO;
        endcase
    end

    always_comb begin
        s_tready_d   = (state_d == S_LO) || (state_d == S_HI);
        // Start is decided one cycle ahead so it is registered yet lands on the first S_RUN cycle
        core_start_d = (state_d == S_RUN) && core_idle && !core_start_q;
        m_tvalid_d   = (state_d == S_OUT);
        busy_d       = (state_d != S_LO);

        core_in_d = core_in_q;
        if ((state_q == S_LO) && s_hs) core_in_d[DW-1:0]    = s_tdata;
        if ((state_q == S_HI) && s_hs) core_in_d[2*DW-1:DW] = s_tdata;

        result_d = result_q;
        seen_d   = seen_q;
        if (core_start_q) begin
            seen_d = 1'b0;
        end else if ((state_q == S_WAIT) && core_out_vld) begin
            result_d = core_out;
            seen_d   = 1'b1;
        end

        m_tdata_d = m_tdata_q;
        m_tuser_d = m_tuser_q;
        if (wait_exit) begin
            if (core_done) begin
                m_tuser_d = !seen_now;
                if (core_out_vld)  m_tdata_d = core_out;
                else if (seen_q)   m_tdata_d = result_q;
                else               m_tdata_d = '0;
            end else begin
                m_tdata_d = DW'(TIMEOUT_CODE);
                m_tuser_d = 1'b1;
            end
        end

        err_d = err_q;
        if (err_now && (err_q != '1)) err_d = err_q + ERRW'(1);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s_tready_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_in_q    <= '0;
            result_q     <= '0;
            seen_q       <= 1'b0;
            m_tdata_q    <= '0;
            m_tuser_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            s_tready_q   <= s_tready_d;
            core_start_q <= core_start_d;
            core_in_q    <= core_in_d;
            result_q     <= result_d;
            seen_q       <= seen_d;
            m_tdata_q    <= m_tdata_d;
            m_tuser_q    <= m_tuser_d;
            m_tvalid_q   <= m_tvalid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign s_tready    = s_tready_q;
    assign core_start  = core_start_q;
    assign core_in_vld = core_start_q;
    assign core_in     = core_in_q;
    assign m_tdata     = m_tdata_q;
    assign m_tuser     = m_tuser_q;
    assign m_tvalid    = m_tvalid_q;
    assign busy        = busy_q;
    assign err_count   = err_q;

endmodule

// File: doc/nn_infer_driver.md
# nn_infer_driver

Sequencing front end for the HLS-generated two-input dense-layer core (ap_ctrl_hs control, packed 32-bit input, 16-bit fixed-point output). It accepts 16-bit feature samples from an upstream AXI-Stream-style source, packs each pair into the core's input word, and runs the core's start/done handshake. It captures the output on its valid strobe and re-presents it on a downstream valid/ready stream. A watchdog bounds each inference so a hung core never stalls the pipeline.

## Interface
Parameters:
- DW, 16, feature and result width (core input word is 2*DW)
- TIMEOUT, 64, max cycles from core_start to core_done before abort (>=4)
- ERRW, 8, width of saturating error counter

Ports:
- ap_clk  in  1  single clock, rising edge
- ap_rst  in  1  synchronous, active-high reset
- s_tdata  in  DW  feature sample, signed Q6.10
- s_tvalid  in  1  sample valid
- s_tready  out  1  sample accepted when s_tvalid & s_tready
- core_start  out  1  ap_start to core
- core_idle  in  1  core ap_idle
- core_done  in  1  core ap_done
- core_in  out  2*DW  packed input: [DW-1:0]=feature0, [2*DW-1:DW]=feature1
- core_in_vld  out  1  input-valid strobe to core
- core_out  in  DW  core result
- core_out_vld  in  1  core result valid
- m_tdata  out  DW  result
- m_tuser  out  1  1 = timeout/missing result (m_tdata is error code)
- m_tvalid  out  1  result valid
- m_tready  in  1  downstream accept
- busy  out  1  state != S_LO
- err_count  out  ERRW  saturating count of errored inferences

## Operation
- FSM states: S_LO, S_HI, S_RUN, S_WAIT, S_OUT.
- S_LO: s_tready=1; on handshake latch s_tdata into core_in[DW-1:0] -> S_HI.
- S_HI: s_tready=1; on handshake latch into core_in[2*DW-1:DW] -> S_RUN.
- S_RUN: s_tready=0; if core_idle=1 assert core_start=1 and core_in_vld=1 for exactly one cycle, clear watchdog, clear result_seen -> S_WAIT; if core_idle=0 hold in S_RUN with core_start=0.
- S_WAIT: core_start=0. Any cycle with core_out_vld=1 latches core_out and sets result_seen (last one wins). On core_done=1 -> S_OUT; m_tuser = ~result_seen' (include a same-cycle core_out_vld); if no result, m_tdata=0. If watchdog reaches TIMEOUT-1 without core_done: m_tdata=16'h8000, m_tuser=1 -> S_OUT.
- Each S_WAIT exit with m_tuser=1 increments err_count, saturating at 2^ERRW-1.
- S_OUT: m_tvalid=1, m_tdata/m_tuser stable until m_tready=1; on handshake -> S_LO. s_tready=0 (no overlap; one inference in flight).
- core_done and watchdog expiry in the same cycle: core_done wins.
- core_in held stable from S_HI capture until next S_LO capture.
- No arithmetic on data; results pass through bit-exact.

## Timing
- Reset values: s_tready=0, core_start=0, core_in_vld=0, core_in=0, m_tvalid=0, m_tuser=0, m_tdata=0, busy=0, err_count=0; state=S_LO. s_tready goes 1 the first cycle after reset deasserts.
- Reset mid-operation: any state returns to S_LO next cycle, partial pair dropped, core_start forced 0, pending result discarded.
- All outputs registered.
- Second sample handshake at cycle t: core_start high at t+1 (core idle). Core done at t+1+L -> m_tvalid high at t+2+L.
- Back-to-back throughput: one result per 4+L cycles with m_tready tied high.

## Structure
- Package nn_drv_pkg: state enum, TIMEOUT_CODE=16'h8000, default DW/TIMEOUT.
- Sub-module nn_watchdog: clear/enable/expire counter, width $clog2(TIMEOUT).
- Core is instantiated by the bench, not by this block.

## Test plan
- Bench core model: out = (x0*-288)>>>10 + (x1*304)>>>10 + 157, latency L=1.
- Samples 0x0400, 0x0400 -> m_tdata=0x00AD, m_tuser=0, m_tvalid at t+3.
- Samples 0x0000, 0x0000 -> m_tdata=0x009D; hold m_tready=0 for 5 cycles -> data stable, s_tready=0 throughout.
- Core never asserts done -> after 64 cycles m_tdata=0x8000, m_tuser=1, err_count=1; 300 such aborts -> err_count=255.
- core_done with no core_out_vld -> m_tdata=0, m_tuser=1; core_idle=0 for 3 cycles in S_RUN -> core_start delayed 3 cycles.
- ap_rst asserted in S_HI and in S_WAIT -> next cycle busy=0, m_tvalid=0; following pair 0x0400, 0x0400 yields 0x00AD.
